// File: rtl/types.sv
`default_nettype none
// ============================================================================
//  Module   : types (package)
//  Purpose  : Shared decode types for the RV32I core: immediate-format
//             selector, major-opcode constants, and the decoded bundle that
//             the decode stage stores and hands to execute.
//  Revision : 1.0 - initial release
// ============================================================================
package types;

  // Immediate format selector consumed by immGen.
  typedef enum logic [2:0] {
    ENUM_IMM_NONE = 3'd0,
    ENUM_IMM_I    = 3'd1,
    ENUM_IMM_S    = 3'd2,
    ENUM_IMM_B    = 3'd3,
    ENUM_IMM_U    = 3'd4,
    ENUM_IMM_J    = 3'd5
  } imm_type_e;

  // RV32I major opcodes (full inst[6:0], including the 2'b11 length bits).
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Everything execute receives except the valid bit.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    imm_type_e   imm_type;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [6:0]  opcode;
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        illegal;
  } id_bundle_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_decode
//  Purpose  : Purely combinational RV32I control decode. Maps an instruction
//             word to an id_bundle_t with register fields, immediate format
//             and class flags. The pc and imm fields are left zero; the
//             enclosing stage fills them.
//  Ports    : inst_i  instruction word
//             dec_o   decoded bundle (pc/imm zero)
//  Config   : ID_ILLEGAL_DETECT_EN - when defined, unknown encodings set
//             dec_o.illegal; otherwise illegal stays 0.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
  import types::*;
(
  input  logic [31:0] inst_i,
  output id_bundle_t  dec_o
);

  // funct7 bits other than bit 30 are not needed by this decoder.
  logic [5:0] w_unused_f7;
  assign w_unused_f7 = {inst_i[31], inst_i[29:25]};

  logic w_we;

  always_comb begin
    dec_o          = '0;
    w_we           = 1'b0;
    dec_o.rs1      = inst_i[19:15];
    dec_o.rs2      = inst_i[24:20];
    dec_o.rd       = inst_i[11:7];
    dec_o.funct3   = inst_i[14:12];
    dec_o.funct7b5 = inst_i[30];
    dec_o.opcode   = inst_i[6:0];

    // Every listed opcode ends in 2'b11, so a non-32-bit encoding
    // (inst[1:0] != 2'b11) always falls through to the default arm.
    case (inst_i[6:0])
      OPC_OP_IMM: begin
        dec_o.imm_type = ENUM_IMM_I;
        w_we           = 1'b1;
      end
      OPC_LOAD: begin
        dec_o.imm_type = ENUM_IMM_I;
        w_we           = 1'b1;
        dec_o.is_load  = 1'b1;
      end
      OPC_JALR: begin
        dec_o.imm_type = ENUM_IMM_I;
        w_we           = 1'b1;
        dec_o.is_jalr  = 1'b1;
      end
      OPC_STORE: begin
        dec_o.imm_type = ENUM_IMM_S;
        dec_o.is_store = 1'b1;
      end
      OPC_BRANCH: begin
        dec_o.imm_type  = ENUM_IMM_B;
        dec_o.is_branch = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_o.imm_type = ENUM_IMM_U;
        w_we           = 1'b1;
      end
      OPC_JAL: begin
        dec_o.imm_type = ENUM_IMM_J;
        w_we           = 1'b1;
        dec_o.is_jal   = 1'b1;
      end
      OPC_OP: begin
        w_we = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        w_we = 1'b0;
      end
      default: begin
`ifdef ID_ILLEGAL_DETECT_EN
        dec_o.illegal = 1'b1;
`else
        w_we = 1'b0;
`endif
      end
    endcase

    // Writes to x0 are architecturally discarded; suppress them here.
    dec_o.reg_we = w_we && (inst_i[11:7] != 5'd0);
  end

endmodule
`default_nettype wire

// File: rtl/immGen.sv
`default_nettype none
// ============================================================================
//  Module   : immGen
//  Purpose  : Forms the sign-extended 32-bit immediate of an RV32I
//             instruction for the selected format; NONE yields zero.
//  Ports    : inst_i      instruction word
//             imm_type_i  immediate format selector
//             imm_o       immediate value
//  Revision : 1.0 - initial release
// ============================================================================
module immGen
  import types::*;
(
  input  logic [31:0] inst_i,
  input  imm_type_e   imm_type_i,
  output logic [31:0] imm_o
);

  // Opcode bits never contribute to an immediate.
  logic [6:0] w_unused_opc;
  assign w_unused_opc = inst_i[6:0];

  always_comb begin
    imm_o = 32'h0;
    case (imm_type_i)
      ENUM_IMM_I: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      ENUM_IMM_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      ENUM_IMM_B: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                           inst_i[30:25], inst_i[11:8], 1'b0};
      ENUM_IMM_U: imm_o = {inst_i[31:12], 12'h000};
      ENUM_IMM_J: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                           inst_i[20], inst_i[30:21], 1'b0};
      default:    imm_o = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage
//  Purpose  : Registered RV32I instruction-decode stage. Decodes fetched
//             inst/pc pairs and forwards the bundle to execute through a
//             two-entry skid buffer (out + skid), so if_ready is registered
//             and has no combinational path from id_ready.
//  Ports    : clk, rst                 clock, synchronous active-high reset
//             if_valid/if_ready        fetch-side handshake
//             if_inst, if_pc           fetched instruction and address
//             flush                    discard held and incoming work
//             id_valid/id_ready        execute-side handshake
//             id_*                     decoded bundle fields
//  Config   : ID_ILLEGAL_DETECT_EN - drives id_illegal for unknown
//             encodings; id_illegal is constant 0 when undefined.
//  Revision : 1.0 - initial release
// ============================================================================
module id_stage
  import types::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_imm,
  output imm_type_e       id_imm_type,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic [2:0]      id_funct3,
  output logic            id_funct7b5,
  output logic [6:0]      id_opcode,
  output logic            id_reg_we,
  output logic            id_is_load,
  output logic            id_is_store,
  output logic            id_is_branch,
  output logic            id_is_jal,
  output logic            id_is_jalr,
  output logic            id_illegal
);

  id_bundle_t  w_dec;
  id_bundle_t  w_in;
  logic [31:0] w_imm;

  id_bundle_t  out_q, out_d;
  id_bundle_t  skid_q, skid_d;
  logic        out_valid_q, out_valid_d;
  logic        skid_valid_q, skid_valid_d;

  logic        w_accept;
  logic        w_consume;

  ctrl_decode u_ctrl_decode (
    .inst_i (if_inst),
    .dec_o  (w_dec)
  );

  // Immediate is formed before storage so held entries carry the final value.
  immGen u_immGen (
    .inst_i     (if_inst),
    .imm_type_i (w_dec.imm_type),
    .imm_o      (w_imm)
  );

  always_comb begin
    w_in     = w_dec;
    w_in.pc  = if_pc;
    w_in.imm = w_imm;
  end

  assign if_ready  = !rst && !skid_valid_q;
  assign w_accept  = if_valid && if_ready && !flush;
  assign w_consume = out_valid_q && id_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (w_consume) begin
      if (skid_valid_q) begin
        // Oldest held entry moves up; a same-cycle accept queues behind it.
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = w_accept;
        if (w_accept) begin
          skid_d = w_in;
        end
      end else begin
        out_valid_d = w_accept;
        if (w_accept) begin
          out_d = w_in;
        end
      end
    end else if (w_accept) begin
      if (!out_valid_q) begin
        out_d       = w_in;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = w_in;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign id_valid     = out_valid_q;
  assign id_pc        = out_q.pc;
  assign id_imm       = out_q.imm;
  assign id_imm_type  = out_q.imm_type;
  assign id_rs1       = out_q.rs1;
  assign id_rs2       = out_q.rs2;
  assign id_rd        = out_q.rd;
  assign id_funct3    = out_q.funct3;
  assign id_funct7b5  = out_q.funct7b5;
  assign id_opcode    = out_q.opcode;
  assign id_reg_we    = out_q.reg_we;
  assign id_is_load   = out_q.is_load;
  assign id_is_store  = out_q.is_store;
  assign id_is_branch = out_q.is_branch;
  assign id_is_jal    = out_q.is_jal;
  assign id_is_jalr   = out_q.is_jalr;
  assign id_illegal   = out_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_stage
//  Purpose  : Directed self-checking bench for id_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage;
  import types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  imm_type_e   id_imm_type;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic [6:0]  id_opcode;
  logic        id_reg_we, id_is_load, id_is_store, id_is_branch;
  logic        id_is_jal, id_is_jalr, id_illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .flush(flush), .id_valid(id_valid),
    .id_ready(id_ready), .id_pc(id_pc), .id_imm(id_imm),
    .id_imm_type(id_imm_type), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_opcode(id_opcode), .id_reg_we(id_reg_we), .id_is_load(id_is_load),
    .id_is_store(id_is_store), .id_is_branch(id_is_branch),
    .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr), .id_illegal(id_illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_valid = 1'b0; if_inst = 32'h0; if_pc = 32'h0;
    flush = 1'b0; id_ready = 1'b1;
    step(); step();
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
    n_checks++; if (if_ready !== 1'b0) begin n_errors++; $display("FAIL reset_if_ready: got %b expected 0", if_ready); end
    n_checks++; if (id_pc !== 32'h0) begin n_errors++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
    n_checks++; if (id_imm !== 32'h0) begin n_errors++; $display("FAIL reset_id_imm: got %h expected 0", id_imm); end
    n_checks++; if (id_imm_type !== ENUM_IMM_NONE) begin n_errors++; $display("FAIL reset_imm_type: got %0d expected 0", id_imm_type); end
    n_checks++; if (id_reg_we !== 1'b0) begin n_errors++; $display("FAIL reset_reg_we: got %b expected 0", id_reg_we); end
    rst = 1'b0;
    #1;
    n_checks++; if (if_ready !== 1'b1) begin n_errors++; $display("FAIL release_if_ready: got %b expected 1", if_ready); end
  endtask

  task automatic test_addi();
    if_valid = 1'b1; if_inst = 32'h00500093; if_pc = 32'h100; id_ready = 1'b1;
    step();
    if_valid = 1'b0;
    n_checks++; if (id_valid !== 1'b1) begin n_errors++; $display("FAIL addi_valid: got %b expected 1", id_valid); end
    n_checks++; if (id_imm !== 32'h5) begin n_errors++; $display("FAIL addi_imm: got %h expected 00000005", id_imm); end
    n_checks++; if (id_imm_type !== ENUM_IMM_I) begin n_errors++; $display("FAIL addi_type: got %0d expected 1", id_imm_type); end
    n_checks++; if (id_rd !== 5'd1) begin n_errors++; $display("FAIL addi_rd: got %0d expected 1", id_rd); end
    n_checks++; if (id_reg_we !== 1'b1) begin n_errors++; $display("FAIL addi_we: got %b expected 1", id_reg_we); end
    n_checks++; if (id_pc !== 32'h100) begin n_errors++; $display("FAIL addi_pc: got %h expected 00000100", id_pc); end
    n_checks++; if (id_opcode !== 7'h13) begin n_errors++; $display("FAIL addi_opcode: got %h expected 13", id_opcode); end
    step();
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL addi_drain: got %b expected 0", id_valid); end
  endtask

  task automatic test_back_to_back();
    if_valid = 1'b1; if_inst = 32'h0020A823; if_pc = 32'h104; id_ready = 1'b1;
    step();
    if_inst = 32'hFE000EE3; if_pc = 32'h108;
    n_checks++; if (id_imm !== 32'h10) begin n_errors++; $display("FAIL sw_imm: got %h expected 00000010", id_imm); end
    n_checks++; if (id_imm_type !== ENUM_IMM_S) begin n_errors++; $display("FAIL sw_type: got %0d expected 2", id_imm_type); end
    n_checks++; if (id_is_store !== 1'b1) begin n_errors++; $display("FAIL sw_store: got %b expected 1", id_is_store); end
    n_checks++; if (id_reg_we !== 1'b0) begin n_errors++; $display("FAIL sw_we: got %b expected 0", id_reg_we); end
    n_checks++; if ({id_rs1, id_rs2, id_funct3} !== {5'd1, 5'd2, 3'd2}) begin n_errors++; $display("FAIL sw_fields: got %h expected %h", {id_rs1, id_rs2, id_funct3}, {5'd1, 5'd2, 3'd2}); end
    step();
    if_valid = 1'b0;
    n_checks++; if (id_valid !== 1'b1) begin n_errors++; $display("FAIL beq_valid: got %b expected 1", id_valid); end
    n_checks++; if (id_imm !== 32'hFFFFFFFC) begin n_errors++; $display("FAIL beq_imm: got %h expected fffffffc", id_imm); end
    n_checks++; if (id_imm_type !== ENUM_IMM_B) begin n_errors++; $display("FAIL beq_type: got %0d expected 3", id_imm_type); end
    n_checks++; if (id_is_branch !== 1'b1) begin n_errors++; $display("FAIL beq_branch: got %b expected 1", id_is_branch); end
    n_checks++; if (id_pc !== 32'h108) begin n_errors++; $display("FAIL beq_pc: got %h expected 00000108", id_pc); end
    step();
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain: got %b expected 0", id_valid); end
  endtask

  task automatic test_lui_jal();
    if_valid = 1'b1; if_inst = 32'h123452B7; if_pc = 32'h10C; id_ready = 1'b1;
    step();
    if_inst = 32'h0000006F; if_pc = 32'h110;
    n_checks++; if (id_imm !== 32'h12345000) begin n_errors++; $display("FAIL lui_imm: got %h expected 12345000", id_imm); end
    n_checks++; if (id_imm_type !== ENUM_IMM_U) begin n_errors++; $display("FAIL lui_type: got %0d expected 4", id_imm_type); end
    n_checks++; if (id_rd !== 5'd5) begin n_errors++; $display("FAIL lui_rd: got %0d expected 5", id_rd); end
    n_checks++; if (id_reg_we !== 1'b1) begin n_errors++; $display("FAIL lui_we: got %b expected 1", id_reg_we); end
    step();
    if_valid = 1'b0;
    n_checks++; if (id_imm_type !== ENUM_IMM_J) begin n_errors++; $display("FAIL jal_type: got %0d expected 5", id_imm_type); end
    n_checks++; if (id_is_jal !== 1'b1) begin n_errors++; $display("FAIL jal_flag: got %b expected 1", id_is_jal); end
    n_checks++; if (id_reg_we !== 1'b0) begin n_errors++; $display("FAIL jal_we_rd0: got %b expected 0", id_reg_we); end
    n_checks++; if (id_imm !== 32'h0) begin n_errors++; $display("FAIL jal_imm: got %h expected 0", id_imm); end
    step();
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    if_valid = 1'b1; if_inst = 32'h00100093; if_pc = 32'h200;
    step();
    n_checks++; if (id_pc !== 32'h200 || id_valid !== 1'b1) begin n_errors++; $display("FAIL stall_a_out: got pc %h v %b expected 00000200 1", id_pc, id_valid); end
    n_checks++; if (if_ready !== 1'b1) begin n_errors++; $display("FAIL stall_rdy1: got %b expected 1", if_ready); end
    if_inst = 32'h00200113; if_pc = 32'h204;
    step();
    n_checks++; if (if_ready !== 1'b0) begin n_errors++; $display("FAIL stall_rdy_fall: got %b expected 0", if_ready); end
    n_checks++; if (id_pc !== 32'h200) begin n_errors++; $display("FAIL stall_hold_a: got %h expected 00000200", id_pc); end
    if_inst = 32'h00300193; if_pc = 32'h208;
    step();
    n_checks++; if (if_ready !== 1'b0 || id_pc !== 32'h200) begin n_errors++; $display("FAIL stall_held: got rdy %b pc %h expected 0 00000200", if_ready, id_pc); end
    id_ready = 1'b1;
    step();
    n_checks++; if (id_pc !== 32'h204 || id_imm !== 32'h2) begin n_errors++; $display("FAIL stall_b_out: got pc %h imm %h expected 00000204 00000002", id_pc, id_imm); end
    n_checks++; if (if_ready !== 1'b1) begin n_errors++; $display("FAIL stall_rdy_rise: got %b expected 1", if_ready); end
    step();
    if_valid = 1'b0;
    n_checks++; if (id_pc !== 32'h208 || id_imm !== 32'h3 || id_valid !== 1'b1) begin n_errors++; $display("FAIL stall_c_out: got pc %h imm %h v %b expected 00000208 00000003 1", id_pc, id_imm, id_valid); end
    n_checks++; if (id_rd !== 5'd3) begin n_errors++; $display("FAIL stall_c_rd: got %0d expected 3", id_rd); end
    step();
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL stall_drain: got %b expected 0", id_valid); end
  endtask

  task automatic test_flush();
    id_ready = 1'b0;
    if_valid = 1'b1; if_inst = 32'h00400213; if_pc = 32'h300;
    step();
    if_inst = 32'h00500293; if_pc = 32'h304;
    step();
    n_checks++; if (if_ready !== 1'b0) begin n_errors++; $display("FAIL flush_full: got %b expected 0", if_ready); end
    if_inst = 32'h00600313; if_pc = 32'h3FC; flush = 1'b1;
    step();
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL flush_valid: got %b expected 0", id_valid); end
    n_checks++; if (if_ready !== 1'b1) begin n_errors++; $display("FAIL flush_rdy: got %b expected 1", if_ready); end
    step();
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL flush_ghost: got %b expected 0", id_valid); end
    if_valid = 1'b1; if_inst = 32'h00700393; if_pc = 32'h400;
    step();
    if_valid = 1'b0;
    n_checks++; if (id_pc !== 32'h400 || id_imm !== 32'h7) begin n_errors++; $display("FAIL flush_resume: got pc %h imm %h expected 00000400 00000007", id_pc, id_imm); end
    step();
  endtask

  task automatic test_reset_midop();
    id_ready = 1'b0;
    if_valid = 1'b1; if_inst = 32'h00800413; if_pc = 32'h500;
    step();
    if_valid = 1'b0; rst = 1'b1;
    step();
    n_checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0) begin n_errors++; $display("FAIL rst_midop: got v %b pc %h expected 0 00000000", id_valid, id_pc); end
    rst = 1'b0; id_ready = 1'b1;
    #1;
    n_checks++; if (if_ready !== 1'b1) begin n_errors++; $display("FAIL rst_midop_rdy: got %b expected 1", if_ready); end
  endtask

  task automatic test_illegal();
    logic exp_ill;
`ifdef ID_ILLEGAL_DETECT_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    if_valid = 1'b1; if_inst = 32'hFFFFFFFF; if_pc = 32'h600; id_ready = 1'b1;
    step();
    if_valid = 1'b0;
    n_checks++; if (id_valid !== 1'b1) begin n_errors++; $display("FAIL ill_valid: got %b expected 1", id_valid); end
    n_checks++; if (id_illegal !== exp_ill) begin n_errors++; $display("FAIL ill_flag: got %b expected %b", id_illegal, exp_ill); end
    n_checks++; if ({id_reg_we, id_is_load, id_is_store, id_is_branch, id_is_jal, id_is_jalr} !== 6'b0) begin n_errors++; $display("FAIL ill_flags: got %b expected 000000", {id_reg_we, id_is_load, id_is_store, id_is_branch, id_is_jal, id_is_jalr}); end
    n_checks++; if (id_imm_type !== ENUM_IMM_NONE) begin n_errors++; $display("FAIL ill_type: got %0d expected 0", id_imm_type); end
    n_checks++; if (id_imm !== 32'h0) begin n_errors++; $display("FAIL ill_imm: got %h expected 0", id_imm); end
    step();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_lui_jal();
    test_stall();
    test_flush();
    test_reset_midop();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_stage.md
# id_stage

Registered instruction-decode stage of the RV32I core, between instruction fetch and execute. Accepts fetched instruction/PC pairs over a valid/ready handshake, decodes the opcode into control flags and an `imm_type_e` selector, and drives the existing `immGen` to form the immediate. The complete decoded bundle goes to execute through a two-entry skid buffer, so `id_ready` has no combinational path to `if_ready`.

## Interface
- `XLEN`, 32: data/PC width; only 32 is supported.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_valid`  in  1  fetch offers `if_inst`/`if_pc`.
- `if_ready`  out  1  stage can accept; registered-only, never depends on `id_ready`.
- `if_inst`  in  32  instruction word.
- `if_pc`  in  32  instruction address.
- `flush`  in  1  discard all held and incoming instructions (branch redirect).
- `id_valid`  out  1  decoded bundle valid.
- `id_ready`  in  1  execute accepts bundle.
- `id_pc`  out  32  PC of bundle.
- `id_imm`  out  32  `immGen` output for the bundle.
- `id_imm_type`  out  `imm_type_e`  selected immediate format.
- `id_rs1`, `id_rs2`, `id_rd`  out  5 each  `inst[19:15]`, `[24:20]`, `[11:7]`.
- `id_funct3`  out  3  `inst[14:12]`.
- `id_funct7b5`  out  1  `inst[30]`.
- `id_opcode`  out  7  `inst[6:0]`.
- `id_reg_we`  out  1  writes `rd`.
- `id_is_load`, `id_is_store`, `id_is_branch`, `id_is_jal`, `id_is_jalr`  out  1 each  class flags.
- `id_illegal`  out  1  illegal encoding; present only under the macro, tied 0 otherwise.

## Operation
- Decode is combinational on `if_inst` before the registers. `immGen` is instantiated once on the input side, so a stored bundle holds the final `imm`.
- Opcode map:
  - `0010011` OP-IMM → I, we.
  - `0000011` LOAD → I, we, load.
  - `1100111` JALR → I, we, jalr.
  - `0100011` STORE → S, store.
  - `1100011` BRANCH → B, branch.
  - `0110111` LUI and `0010111` AUIPC → U, we.
  - `1101111` JAL → J, we, jal.
  - `0110011` OP → NONE, we.
  - `0001111` FENCE and `1110011` SYSTEM → NONE, no flags.
  - Any other opcode, or `inst[1:0]` ≠ `11` → NONE, all flags 0, treated as illegal.
- `id_reg_we` is forced to 0 when `rd` = 0.
- Storage is an output register (`out_q`, `out_valid_q`) plus a skid register (`skid_q`, `skid_valid_q`).
- `if_ready` = `!rst && !skid_valid_q`.
- Accept (`if_valid && if_ready && !flush`):
  - Load `out_q` if `out_valid_q` is 0 or `id_ready` is 1.
  - Otherwise load `skid_q`.
- Consume (`out_valid_q && id_ready`): if `skid_valid_q`, move skid → out and clear skid, and any accept in the same cycle lands in the skid. Otherwise the output empties unless refilled by a same-cycle accept.
- Order is strictly FIFO. Data registers update only on load; valid bits alone gate meaning.
- `flush` clears both valid bits that cycle, has priority over accept and consume, and drops any offered input.

## Timing
- Latency 1 cycle: an instruction accepted at edge N is on `id_*` with `id_valid`=1 after edge N.
- Throughput 1 instruction/cycle while `id_ready`=1.
- On the first stall cycle one more instruction is absorbed into the skid. `if_ready` falls the next cycle and rises the cycle after skid drains.
- Reset values:
  - `id_valid`=0 and `if_ready`=0 while `rst` is high; `if_ready`=1 in the first cycle after release.
  - All data outputs 0, `id_imm_type`=`ENUM_IMM_NONE`.
- Reset mid-operation: held instructions are discarded the same as flush.
- Simultaneous `flush` with a handshake on either side: both transfers are void, and the stage is empty next cycle.

## Configuration
- `ID_ILLEGAL_DETECT_EN` defined:
  - The illegal-encoding rule drives `id_illegal`=1 for the bundle.
  - The bundle still passes with all flags 0.
- Undefined: `id_illegal` is constant 0, and illegal words pass as NONE-type no-ops with no flag logic compiled.

## Structure
- Shared `types` package:
  - Existing `imm_type_e` (`ENUM_IMM_NONE/I/S/B/U/J`).
  - New opcode localparams (`OPC_OP_IMM`, `OPC_LOAD`, …).
  - A packed struct `id_bundle_t` holding every `id_*` field except `id_valid`; it is the storage type of `out_q`/`skid_q`.
- One natural sub-module, `ctrl_decode`: purely combinational, mapping `inst` → `id_bundle_t` minus `imm`, including `imm_type`. `id_stage` wires its `imm_type` into `immGen`.

## Test plan
- `0x00500093` (addi x1,x0,5), `id_ready`=1 → next cycle `id_valid`=1, `id_imm`=`0x00000005`, I, `id_rd`=1, `id_reg_we`=1.
- `0x0020A823` (sw x2,16(x1)) then `0xFE000EE3` (beq x0,x0,-4), back to back:
  - First: `id_imm`=`0x10`, S, store=1, we=0.
  - Second: `id_imm`=`0xFFFFFFFC`, B, branch=1.
- `0x123452B7` (lui x5,0x12345) → `id_imm`=`0x12345000`, U, rd=5. `0x0000006F` (jal x0,0) → J, jal=1, `id_reg_we`=0 (rd=0).
- Hold `id_ready`=0 and offer 3 instructions:
  - First two captured (out + skid).
  - `if_ready`=0 from the cycle after the second accept; the third is held by fetch.
  - Release `id_ready` → all three emerge in order, one per cycle.
- With out and skid full, assert `flush` for 1 cycle alongside `if_valid`=1 → next cycle `id_valid`=0, `if_ready`=1, nothing from the flushed cycle ever appears.
- `0xFFFFFFFF`:
  - With `ID_ILLEGAL_DETECT_EN`: `id_illegal`=1, all flags 0, `id_imm_type`=NONE, `id_imm`=0.
  - Without it: `id_illegal`=0, same other outputs.
